sreg_rx: RTL
============

SREG_RX -- requirements
Module: sreg_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 42, the frame length in bits.
REQ-002 SHALL have parameter TIMEOUT, default 64, the maximum clk cycles allowed between consecutive shift strobes inside a frame.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port shift, input, 1 bit: bit strobe from the upstream shift-register controller; one bit per high cycle.
REQ-006 SHALL have port sdata, input, 1 bit: serial data, LSB first, valid in cycles where shift=1.
REQ-007 SHALL have port clr_err, input, 1 bit: clears the sticky overflow flag.
REQ-008 SHALL have port frame_ready, input, 1 bit: consumer accepts frame_data.
REQ-009 SHALL have port frame_data, output, WIDTH bits: last completed frame.
REQ-010 SHALL have port frame_valid, output, 1 bit: frame_data holds an unconsumed frame.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, a completed frame was dropped.
REQ-012 SHALL have port timeout_err, output, 1 bit: one-cycle pulse, partial frame discarded.
REQ-013 SHALL have port busy, output, 1 bit: high while a frame is partially received.

Function
REQ-014 SHALL sample shift and sdata on the same rising clk edge; shift=0 cycles are ignored for data.
REQ-015 SHALL implement a two-state FSM: IDLE and RECV.
REQ-016 IDLE: on shift=1, SHALL load sdata into bit WIDTH-1 of the assembly register, set bit_cnt=1 and go to RECV.
REQ-017 RECV: on shift=1, SHALL right-shift the assembly register with sdata entering at bit WIDTH-1, increment bit_cnt, and clear the gap counter.
REQ-018 SHALL store the first bit received in frame_data[0] and the last bit received in frame_data[WIDTH-1].
REQ-019 On the WIDTH-th strobe, SHALL go to IDLE and set bit_cnt=0; the completed frame becomes visible at frame_data with frame_valid=1 on the next cycle, giving a latency of 1 cycle from the final sampling edge.
REQ-020 SHALL hold frame_data and frame_valid stable until frame_valid=1 and frame_ready=1 in the same cycle; frame_valid then clears on the next edge.
REQ-021 If a frame completes while frame_valid=1 and frame_ready=0, SHALL keep the old frame_data, drop the new frame and set overflow=1.
REQ-022 If a frame completes in the same cycle as an accepting handshake, SHALL load the new frame, keep frame_valid=1 and leave overflow unchanged.
REQ-023 In RECV, SHALL count consecutive shift=0 cycles; when the count reaches TIMEOUT, SHALL discard the partial frame, pulse timeout_err for 1 cycle and go to IDLE.
REQ-024 The gap counter and bit_cnt SHALL be wide enough for their parameters and SHALL NOT wrap within a frame.
REQ-025 SHALL hold overflow at 1 until clr_err=1; if clr_err and a new overflow event occur in the same cycle, overflow SHALL remain 1.
REQ-026 busy SHALL equal (state==RECV).
REQ-027 Reception SHALL continue independently of the frame_valid and frame_ready handshake.

Reset
REQ-028 With rst_n=0 at a clk edge, SHALL force state=IDLE, bit_cnt=0, gap counter=0, frame_data=0, frame_valid=0, overflow=0, timeout_err=0 and busy=0.
REQ-029 A reset mid-frame or mid-handshake SHALL discard all partial and pending data; the first shift after reset SHALL be treated as bit 0.

Verification
REQ-030 Send 42 strobes carrying 42'h2AA_5555_AAAA LSB first with frame_ready=1 -> frame_valid=1 one cycle after the 42nd strobe, frame_data=42'h2AA_5555_AAAA, then frame_valid=0 one cycle later.
REQ-031 Send two frames 42'h1 and 42'h3FF_FFFF_FFFF with frame_ready=0 -> frame_data stays 42'h1 and overflow=1; pulse clr_err -> overflow=0.
REQ-032 Send a second frame whose completion coincides with the handshake of the first -> frame_valid stays 1, frame_data switches to the second frame, overflow=0.
REQ-033 Send 10 strobes followed by 64 idle cycles -> timeout_err pulses once and busy=0; then send a full 42'h0F0F -> received as 42'h0F0F with no bit misalignment.
REQ-034 Assert rst_n=0 for 1 cycle after 20 strobes -> all outputs 0; the next 42 strobes of 42'h155_5555_5555 -> frame_data=42'h155_5555_5555.
REQ-035 Send strobes with random 0-5 cycle gaps (all below TIMEOUT) -> frame_data is correct and timeout_err never asserts.

Source files
------------

// File: rtl/sreg_rx.sv
`default_nettype none
// ============================================================================
// Module   : sreg_rx
// Brief    : Serial-to-parallel frame receiver (LSB first) with a valid/ready
//            output handshake, inter-strobe timeout and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module sreg_rx #(
    parameter int WIDTH   = 42,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift,
    input  logic             sdata,
    input  logic             clr_err,
    input  logic             frame_ready,
    output logic [WIDTH-1:0] frame_data,
    output logic             frame_valid,
    output logic             overflow,
    output logic             timeout_err,
    output logic             busy
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam int c_GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_asm;
    logic [WIDTH-1:0]   w_asm_next;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_CNT_W-1:0] w_bit_cnt_next;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_GAP_W-1:0] w_gap_cnt_next;
    logic               w_complete;
    logic               w_timeout;
    logic               w_accept;
    logic               w_load;
    logic               w_drop;
    logic [WIDTH-1:0]   r_frame_data;
    logic               r_frame_valid;
    logic               r_overflow;
    logic               r_timeout_err;

    // New bits enter at the top, so after WIDTH strobes the first bit sits at bit 0.
    assign w_asm_next = {sdata, r_asm[WIDTH-1:1]};
    assign w_accept   = r_frame_valid & frame_ready;
    assign w_load     = w_complete & (~r_frame_valid | w_accept);
    assign w_drop     = w_complete & r_frame_valid & ~frame_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_gap_cnt_next = r_gap_cnt;
        w_complete     = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            S_IDLE, S_RECV: begin
                if (shift) begin
                    w_gap_cnt_next = '0;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_complete     = 1'b1;
                        w_bit_cnt_next = '0;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + c_CNT_W'(1);
                        w_state_next   = S_RECV;
                    end
                end else if (r_state == S_RECV) begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        w_timeout      = 1'b1;
                        w_bit_cnt_next = '0;
                        w_gap_cnt_next = '0;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_gap_cnt_next = r_gap_cnt + c_GAP_W'(1);
                    end
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_bit_cnt_next = '0;
                w_gap_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_asm         <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_frame_data  <= '0;
            r_frame_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_bit_cnt     <= w_bit_cnt_next;
            r_gap_cnt     <= w_gap_cnt_next;
            r_timeout_err <= w_timeout;
            if (shift) begin
                r_asm <= w_asm_next;
            end
            if (w_load) begin
                r_frame_data  <= w_asm_next;
                r_frame_valid <= 1'b1;
            end else if (w_accept) begin
                r_frame_valid <= 1'b0;
            end
            // A fresh drop outranks a simultaneous clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign frame_data  = r_frame_data;
    assign frame_valid = r_frame_valid;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state == S_RECV);

endmodule
`default_nettype wire
